// File: rtl/sram_uart_dump.sv
// SRAM-to-UART read-back: parses an 8-byte (address, count) header from the UART RX
// stream and sends that many SRAM bytes to the UART TX. Option: SRAM_DUMP_CHECKSUM_EN.
module sram_uart_dump #(
   parameter int READ_WAIT = 2
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        dump,
   input  logic [7:0]  rx_data,
   input  logic        rx_recv,
   output logic [7:0]  tx_data,
   output logic        tx_send,
   input  logic        tx_busy,
   output logic [18:0] mem_addr,
   output logic        mem_load,
   input  logic [7:0]  mem_rdata,
   output logic        busy,
   output logic        done
);

   localparam int WW = (READ_WAIT < 1) ? 1 : $clog2(READ_WAIT + 1);
   localparam logic [WW-1:0] WAIT_INIT = WW'(READ_WAIT);

   typedef enum logic [2:0] {
      S_HDR, S_READ, S_SEND, S_DRAIN, S_CSUM, S_END
   } state_t;

   state_t state, state_nx;

   logic          rx_q;
   logic [2:0]    hdr_cnt;
   // Only the low 19 address bits can ever reach the SRAM, so only those are kept;
   // incrementing them wraps 0x7FFFF -> 0x00000 exactly like the full 32-bit address.
   logic [18:0]   addr_lo;
   logic [31:0]   count32;
   logic [31:0]   count_nx;
   logic [7:0]    tx_reg;
   logic [WW-1:0] wait_cnt;
   logic          accept;
   logic          hdr_last;
`ifdef SRAM_DUMP_CHECKSUM_EN
   logic [7:0]    sum;
   logic          csum_done;
`endif

   assign accept   = rx_recv & ~rx_q & (state == S_HDR);
   assign hdr_last = accept & (hdr_cnt == 3'd7);
   assign count_nx = {count32[23:0], rx_data};

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= S_HDR;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_HDR: begin
            if (hdr_last) begin
`ifdef SRAM_DUMP_CHECKSUM_EN
               state_nx = (count_nx == 32'd0) ? S_CSUM : S_READ;
`else
               state_nx = (count_nx == 32'd0) ? S_END : S_READ;
`endif
            end
         end
         S_READ:  if (wait_cnt == '0) state_nx = S_SEND;
         S_SEND:  if (tx_busy) state_nx = S_DRAIN;
         S_DRAIN: begin
            if (!tx_busy) begin
`ifdef SRAM_DUMP_CHECKSUM_EN
               if (csum_done)              state_nx = S_END;
               else if (count32 == 32'd1)  state_nx = S_CSUM;
               else                        state_nx = S_READ;
`else
               state_nx = (count32 == 32'd1) ? S_END : S_READ;
`endif
            end
         end
         S_CSUM:  state_nx = S_SEND;
         S_END:   state_nx = S_HDR;
         default: state_nx = S_HDR;
      endcase
      if (!dump) state_nx = S_HDR;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rx_q      <= 1'b0;
         hdr_cnt   <= 3'd0;
         addr_lo   <= '0;
         count32   <= '0;
         tx_reg    <= '0;
         wait_cnt  <= '0;
`ifdef SRAM_DUMP_CHECKSUM_EN
         sum       <= '0;
         csum_done <= 1'b0;
`endif
      end else begin
         rx_q <= rx_recv;
         if (!dump) begin
            hdr_cnt   <= 3'd0;
            tx_reg    <= '0;
            wait_cnt  <= '0;
`ifdef SRAM_DUMP_CHECKSUM_EN
            sum       <= '0;
            csum_done <= 1'b0;
`endif
         end else begin
            case (state)
               S_HDR: begin
                  if (accept) begin
                     hdr_cnt <= hdr_cnt + 3'd1;
                     if (!hdr_cnt[2]) addr_lo <= {addr_lo[10:0], rx_data};
                     else             count32 <= count_nx;
                     if (hdr_last) wait_cnt <= WAIT_INIT;
                  end
               end
               S_READ: begin
                  if (wait_cnt == '0) begin
                     tx_reg <= mem_rdata;
`ifdef SRAM_DUMP_CHECKSUM_EN
                     sum    <= sum + mem_rdata;
`endif
                  end else begin
                     wait_cnt <= wait_cnt - 1'b1;
                  end
               end
               S_DRAIN: begin
                  if (!tx_busy) begin
                     addr_lo  <= addr_lo + 19'd1;
                     count32  <= count32 - 32'd1;
                     wait_cnt <= WAIT_INIT;
                  end
               end
`ifdef SRAM_DUMP_CHECKSUM_EN
               S_CSUM: begin
                  tx_reg    <= ~sum + 8'd1;
                  csum_done <= 1'b1;
               end
`endif
               S_END: begin
                  hdr_cnt <= 3'd0;
`ifdef SRAM_DUMP_CHECKSUM_EN
                  sum       <= '0;
                  csum_done <= 1'b0;
`endif
               end
               default: ;
            endcase
         end
      end
   end

   assign mem_load = (state == S_READ);
   assign mem_addr = mem_load ? addr_lo : '0;
   assign tx_send  = (state == S_SEND);
   assign tx_data  = tx_reg;
   assign busy     = (state == S_HDR) ? (hdr_cnt != 3'd0) : (state != S_END);
   assign done     = (state == S_END);

endmodule

// File: tb/tb_sram_uart_dump.sv
// Bench for sram_uart_dump: directed and random header streams checked against a
// queue model of the expected UART TX bytes and SRAM addresses.
module tb_sram_uart_dump;

   localparam int RW = 2;

   logic        clock;
   logic        resetn;
   logic        dump;
   logic [7:0]  rx_data;
   logic        rx_recv;
   logic [7:0]  tx_data;
   logic        tx_send;
   logic        tx_busy;
   logic [18:0] mem_addr;
   logic        mem_load;
   logic [7:0]  mem_rdata;
   logic        busy;
   logic        done;

   logic [7:0]  mem [0:524287];

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_q[$];
   logic [18:0] exp_addr_q[$];
   logic [7:0]  got_q[$];
   logic [18:0] addr_q[$];

   int  done_cnt  = 0;
   int  viol_cnt  = 0;
   int  hold_viol = 0;
   int  stall     = 0;
   int  busy_len  = 1;
   bit  tx_en     = 1'b0;

   logic [7:0] prev_data;
   logic       prev_send, prev_busy, prev_load;

   sram_uart_dump #(.READ_WAIT(RW)) dut (
      .clock(clock), .resetn(resetn), .dump(dump),
      .rx_data(rx_data), .rx_recv(rx_recv),
      .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
      .mem_addr(mem_addr), .mem_load(mem_load), .mem_rdata(mem_rdata),
      .busy(busy), .done(done)
   );

   assign mem_rdata = mem[mem_addr];

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // UART transmitter stand-in: optional stall before accepting, then busy for busy_len cycles.
   initial begin
      tx_busy = 1'b0;
      forever begin
         tick();
         if (tx_en && tx_send === 1'b1) begin
            repeat (stall) begin
               tick();
               if (tx_send !== 1'b1) hold_viol++;
            end
            got_q.push_back(tx_data);
            tx_busy = 1'b1;
            repeat (busy_len) tick();
            tx_busy = 1'b0;
         end
      end
   end

   always @(negedge clock) begin
      if (done === 1'b1) done_cnt++;
      if (mem_load === 1'b1 && tx_send === 1'b1) viol_cnt++;
      if (resetn === 1'b1 && (prev_send === 1'b1 || prev_busy === 1'b1) && tx_data !== prev_data)
         viol_cnt++;
      if (mem_load === 1'b1 && prev_load !== 1'b1) addr_q.push_back(mem_addr);
      prev_data = tx_data;
      prev_send = tx_send;
      prev_busy = tx_busy;
      prev_load = mem_load;
   end

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_recv = 1'b1;
      repeat (2) tick();
      rx_recv = 1'b0;
      repeat (2) tick();
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_tx_send"},  {31'd0, tx_send},  32'd0);
      check({tag, "_mem_load"}, {31'd0, mem_load}, 32'd0);
      check({tag, "_busy"},     {31'd0, busy},     32'd0);
      check({tag, "_done"},     {31'd0, done},     32'd0);
      check({tag, "_tx_data"},  {24'd0, tx_data},  32'd0);
      check({tag, "_mem_addr"}, {13'd0, mem_addr}, 32'd0);
   endtask

   task automatic run_stream(input logic [31:0] a, input logic [31:0] c,
                             input int st, input int bl, input string tag);
      logic [7:0]  hdr [8];
      logic [7:0]  sum;
      logic [7:0]  b;
      int          lat;
      int          k;
      int          base_done;
      int          base_viol;
      int          base_hold;
      exp_q.delete();
      exp_addr_q.delete();
      sum = 8'd0;
      for (int i = 0; i < int'(c); i++) begin
         b = mem[19'(a + 32'(i))];
         exp_q.push_back(b);
         exp_addr_q.push_back(19'(a + 32'(i)));
         sum = sum + b;
      end
`ifdef SRAM_DUMP_CHECKSUM_EN
      exp_q.push_back(8'd0 - sum);
`endif
      stall    = st;
      busy_len = bl;
      tx_en    = 1'b1;
      got_q.delete();
      addr_q.delete();
      base_done = done_cnt;
      base_viol = viol_cnt;
      base_hold = hold_viol;
      {hdr[0], hdr[1], hdr[2], hdr[3]} = a;
      {hdr[4], hdr[5], hdr[6], hdr[7]} = c;
      for (int i = 0; i < 7; i++) send_byte(hdr[i]);
      rx_data = hdr[7];
      rx_recv = 1'b1;
      lat = 0;
      while (tx_send !== 1'b1 && lat < 60) begin
         tick();
         lat++;
         if (lat == 2) rx_recv = 1'b0;
      end
      rx_recv = 1'b0;
      if (c != 32'd0) check({tag, "_latency"}, lat, RW + 2);
      k = 0;
      while (done_cnt == base_done && k < 3000) begin
         tick();
         k++;
         if (k == 3 && busy === 1'b1) begin
            rx_data = 8'hEE;
            rx_recv = 1'b1;
         end
         if (k == 5) rx_recv = 1'b0;
      end
      rx_recv = 1'b0;
      repeat (4) tick();
      check({tag, "_done_pulses"}, done_cnt - base_done, 1);
      check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
      check({tag, "_tx_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_tx_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
      check({tag, "_addr_count"}, addr_q.size(), exp_addr_q.size());
      for (int i = 0; i < exp_addr_q.size() && i < addr_q.size(); i++)
         check($sformatf("%s_addr%0d", tag, i), {13'd0, addr_q[i]}, {13'd0, exp_addr_q[i]});
      check({tag, "_protocol"}, viol_cnt - base_viol, 0);
      check({tag, "_send_hold"}, hold_viol - base_hold, 0);
   endtask

   initial begin
      int t;
      resetn  = 1'b0;
      dump    = 1'b0;
      rx_data = 8'h00;
      rx_recv = 1'b0;
      for (int i = 0; i < 524288; i++) mem[i] = 8'($urandom);
      mem[19'h00100] = 8'h11;
      mem[19'h00101] = 8'h22;
      mem[19'h00102] = 8'h33;
      mem[19'h00103] = 8'h44;
      mem[19'h7FFFF] = 8'hAA;
      mem[19'h00000] = 8'hBB;
      mem[19'h00200] = 8'h01;
      mem[19'h00201] = 8'h02;
      mem[19'h00202] = 8'h03;
      repeat (3) tick();
      check_idle("reset");
      resetn = 1'b1;
      tick();
      dump = 1'b1;
      tick();
      check_idle("dump_on");

      // Reset pulse while a byte is being offered to the transmitter.
      tx_en = 1'b0;
      for (int i = 0; i < 7; i++) send_byte((i == 6) ? 8'h01 : 8'h00);
      send_byte(8'h04);
      t = 0;
      while (tx_send !== 1'b1 && t < 100) begin
         tick();
         t++;
      end
      check("mid_reset_in_send", {31'd0, tx_send}, 32'd1);
      resetn = 1'b0;
      #1;
      check_idle("mid_reset");
      tick();
      resetn = 1'b1;
      tick();
      check_idle("after_reset");

      run_stream(32'h0000_0100, 32'd4, 0, 2, "basic4");
      run_stream(32'h0000_0010, 32'd0, 0, 1, "count0");
      run_stream(32'h0007_FFFF, 32'd2, 1, 1, "wrap");

      // Header abandoned by dropping dump partway through.
      for (int i = 0; i < 5; i++) send_byte(8'h00);
      check("partial_busy", {31'd0, busy}, 32'd1);
      dump = 1'b0;
      tick();
      check_idle("dump_off");
      tick();
      dump = 1'b1;
      tick();
      run_stream(32'h0000_0000, 32'd1, 0, 1, "after_abort");

      run_stream(32'h0000_0200, 32'd3, 20, 20, "stall20");

      for (int r = 0; r < 6; r++) begin
         logic [31:0] ra;
         ra = $urandom;
         if (r == 2) ra = {ra[31:19], 19'h7FFFD};
         run_stream(ra, 32'($urandom_range(1, 6)), $urandom_range(0, 3),
                    $urandom_range(1, 4), $sformatf("rand%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
